// File: rtl/weather_pkg.sv
// Shared types for the weather supervisor: alert state encoding and visibility codes.
package weather_pkg;

  typedef enum logic [1:0] {
    WX_CLEAR     = 2'b00,
    WX_CAUTION   = 2'b01,
    WX_SEVERE    = 2'b10,
    WX_EMERGENCY = 2'b11
  } wx_state_t;

  localparam logic [1:0] VIS_GOOD  = 2'b00;
  localparam logic [1:0] VIS_RED_A = 2'b01;
  localparam logic [1:0] VIS_RED_B = 2'b10;
  localparam logic [1:0] VIS_ZERO  = 2'b11;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wx_persist_counter.sv
// Consecutive-true counter: done_c flags the cycle on which cond has held for TARGET cycles.
module wx_persist_counter #(
  parameter int unsigned W      = 1,
  parameter int unsigned TARGET = 1,
  parameter int unsigned SAT    = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic cond,
  input  logic clr,
  output logic done_c
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (RST || clr || !cond) begin
      cnt_d = '0;
    end else if (cnt_q != W'(SAT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  assign done_c = cond && (cnt_q >= W'(TARGET - 1));

  always_ff @(posedge CLK) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/weather_supervisor.sv
// Weather alert supervisor with escalation persistence and relax hold-off.
// Optional WSU_EVENT_LOG_EN adds saturating SEVERE/EMERGENCY entry counters.
module weather_supervisor
  import weather_pkg::*;
#(
  parameter int unsigned WIND_W       = 6,
  parameter int unsigned TEMP_W       = 8,
  parameter int unsigned WIND_CAUTION = 10,
  parameter int unsigned WIND_SEVERE  = 15,
  parameter int unsigned WIND_EMERG   = 20,
  parameter int          TEMP_SEVERE  = 35,
  parameter int          TEMP_EMERG   = 40,
  parameter int unsigned PERSIST      = 1,
  parameter int unsigned HOLD         = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     thunderstorm,
  input  logic [WIND_W-1:0]        wind,
  input  logic [1:0]               visibility,
  input  logic signed [TEMP_W-1:0] temperature,
  input  logic                     alert_ack,
  output logic                     severe_weather,
  output logic                     emergency_landing_alert,
  output logic [1:0]               wx_state
`ifdef WSU_EVENT_LOG_EN
  ,
  output logic [7:0]               severe_events,
  output logic [7:0]               emerg_events
`endif
);

  localparam int unsigned SAT   = max_u(PERSIST, HOLD);
  localparam int unsigned CNT_W = $clog2(SAT + 1);

  localparam logic signed [TEMP_W-1:0] T_SEV_HI = TEMP_W'(TEMP_SEVERE);
  localparam logic signed [TEMP_W-1:0] T_SEV_LO = TEMP_W'(-TEMP_SEVERE);
  localparam logic signed [TEMP_W-1:0] T_EMG_HI = TEMP_W'(TEMP_EMERG);
  localparam logic signed [TEMP_W-1:0] T_EMG_LO = TEMP_W'(-TEMP_EMERG);

  wx_state_t state_q, state_d;
  logic      sev_out_q, sev_out_d;
  logic      emg_out_q, emg_out_d;
  logic      sev_c, emg_c, cau_c, clr_c;
  logic      esc_cond_c, rel_cond_c, esc_done_c, rel_done_c, chg_c;

  // Instantaneous weather classification
  always_comb begin
    sev_c = thunderstorm || (wind > WIND_W'(WIND_SEVERE)) || (temperature > T_SEV_HI) ||
            (temperature < T_SEV_LO) || (visibility == VIS_ZERO);
    emg_c = (wind > WIND_W'(WIND_EMERG)) || (temperature > T_EMG_HI) || (temperature < T_EMG_LO);
    cau_c = !sev_c && ((wind > WIND_W'(WIND_CAUTION)) ||
                       (visibility == VIS_RED_A) || (visibility == VIS_RED_B));
    clr_c = !sev_c && !cau_c;
  end

  // Escalate/relax conditions that apply to the current state
  always_comb begin
    esc_cond_c = 1'b0;
    rel_cond_c = 1'b0;
    case (state_q)
      WX_CLEAR:   esc_cond_c = sev_c || cau_c;
      WX_CAUTION: begin
        esc_cond_c = sev_c;
        rel_cond_c = clr_c;
      end
      WX_SEVERE:  begin
        esc_cond_c = emg_c;
        rel_cond_c = !sev_c;
      end
      default:    ;
    endcase
  end

  wx_persist_counter #(.W(CNT_W), .TARGET(PERSIST), .SAT(SAT)) u_esc (
    .CLK(CLK), .RST(RST), .cond(esc_cond_c), .clr(chg_c), .done_c(esc_done_c)
  );

  wx_persist_counter #(.W(CNT_W), .TARGET(HOLD), .SAT(SAT)) u_rel (
    .CLK(CLK), .RST(RST), .cond(rel_cond_c), .clr(chg_c), .done_c(rel_done_c)
  );

  // Next state; escalation takes priority over relaxation
  always_comb begin
    state_d = state_q;
    if (RST) begin
      state_d = WX_CLEAR;
    end else begin
      case (state_q)
        WX_CLEAR:     if (esc_done_c) state_d = sev_c ? WX_SEVERE : WX_CAUTION;
        WX_CAUTION:   if (esc_done_c) state_d = WX_SEVERE;
                      else if (rel_done_c) state_d = WX_CLEAR;
        WX_SEVERE:    if (esc_done_c) state_d = WX_EMERGENCY;
                      else if (rel_done_c) state_d = WX_CAUTION;
        WX_EMERGENCY: if (alert_ack && !emg_c) state_d = WX_SEVERE;
        default:      state_d = WX_CLEAR;
      endcase
    end
    chg_c     = (state_d != state_q);
    sev_out_d = (state_d == WX_SEVERE) || (state_d == WX_EMERGENCY);
    emg_out_d = (state_d == WX_EMERGENCY);
  end

  always_ff @(posedge CLK) begin
    state_q   <= state_d;
    sev_out_q <= sev_out_d;
    emg_out_q <= emg_out_d;
  end

  assign wx_state                = state_q;
  assign severe_weather          = sev_out_q;
  assign emergency_landing_alert = emg_out_q;

`ifdef WSU_EVENT_LOG_EN
  logic [7:0] sev_ev_q, sev_ev_d;
  logic [7:0] emg_ev_q, emg_ev_d;

  // Saturating entry counters; SEVERE entered from EMERGENCY is not an event
  always_comb begin
    sev_ev_d = sev_ev_q;
    emg_ev_d = emg_ev_q;
    if (RST) begin
      sev_ev_d = '0;
      emg_ev_d = '0;
    end else begin
      if ((state_d == WX_SEVERE) && ((state_q == WX_CLEAR) || (state_q == WX_CAUTION)) &&
          (sev_ev_q != 8'hFF)) begin
        sev_ev_d = sev_ev_q + 8'd1;
      end
      if ((state_d == WX_EMERGENCY) && (state_q != WX_EMERGENCY) && (emg_ev_q != 8'hFF)) begin
        emg_ev_d = emg_ev_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    sev_ev_q <= sev_ev_d;
    emg_ev_q <= emg_ev_d;
  end

  assign severe_events = sev_ev_q;
  assign emerg_events  = emg_ev_q;
`endif

endmodule

// File: tb/tb_weather_supervisor.sv
// Bench for weather_supervisor: two instances (default and PERSIST=3/HOLD=4) share stimulus;
// a reference model queues expected outputs and a monitor compares each cycle.
module tb_weather_supervisor;

  logic              CLK = 1'b0;
  logic              RST;
  logic              thunderstorm;
  logic [5:0]        wind;
  logic [1:0]        visibility;
  logic signed [7:0] temperature;
  logic              alert_ack;

  logic       sev_a, emg_a, sev_b, emg_b;
  logic [1:0] st_a, st_b;
`ifdef WSU_EVENT_LOG_EN
  logic [7:0] sev_ev_a, emg_ev_a, sev_ev_b, emg_ev_b;
`endif

  always #5 CLK = ~CLK;

  weather_supervisor dut_a (
    .CLK(CLK), .RST(RST), .thunderstorm(thunderstorm), .wind(wind), .visibility(visibility),
    .temperature(temperature), .alert_ack(alert_ack),
    .severe_weather(sev_a), .emergency_landing_alert(emg_a), .wx_state(st_a)
`ifdef WSU_EVENT_LOG_EN
    , .severe_events(sev_ev_a), .emerg_events(emg_ev_a)
`endif
  );

  weather_supervisor #(.PERSIST(3), .HOLD(4)) dut_b (
    .CLK(CLK), .RST(RST), .thunderstorm(thunderstorm), .wind(wind), .visibility(visibility),
    .temperature(temperature), .alert_ack(alert_ack),
    .severe_weather(sev_b), .emergency_landing_alert(emg_b), .wx_state(st_b)
`ifdef WSU_EVENT_LOG_EN
    , .severe_events(sev_ev_b), .emerg_events(emg_ev_b)
`endif
  );

  typedef struct {
    int st;
    int sevw;
    int emgw;
    int sev_ev;
    int emg_ev;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   errors = 0;

  int m_st[2], m_esc[2], m_rel[2], m_sev_ev[2], m_emg_ev[2];
  int m_p[2] = '{1, 3};
  int m_h[2] = '{1, 4};

  // Reference model: level 0..3 plus run lengths of the active escalate/relax condition
  task automatic model_step(input int d);
    int   w, t, v, nxt;
    bit   sev, emg, cau, clr, e, r;
    exp_t x;
    w = int'(wind);
    t = int'(temperature);
    v = int'(visibility);
    if (RST) begin
      m_st[d] = 0; m_esc[d] = 0; m_rel[d] = 0; m_sev_ev[d] = 0; m_emg_ev[d] = 0;
    end else begin
      sev = thunderstorm || w > 15 || t > 35 || t < -35 || v == 3;
      emg = w > 20 || t > 40 || t < -40;
      cau = !sev && (w > 10 || v == 1 || v == 2);
      clr = !sev && !cau;
      e = 1'b0;
      r = 1'b0;
      if (m_st[d] == 0) e = sev || cau;
      if (m_st[d] == 1) begin e = sev; r = clr; end
      if (m_st[d] == 2) begin e = emg; r = !sev; end
      m_esc[d] = e ? m_esc[d] + 1 : 0;
      m_rel[d] = r ? m_rel[d] + 1 : 0;
      nxt = m_st[d];
      if (m_st[d] == 3) begin
        if (alert_ack && !emg) nxt = 2;
      end else if (m_esc[d] >= m_p[d]) begin
        nxt = (m_st[d] == 0) ? (sev ? 2 : 1) : m_st[d] + 1;
      end else if (m_rel[d] >= m_h[d]) begin
        nxt = m_st[d] - 1;
      end
      if (nxt == 2 && m_st[d] < 2 && m_sev_ev[d] < 255) m_sev_ev[d]++;
      if (nxt == 3 && m_st[d] != 3 && m_emg_ev[d] < 255) m_emg_ev[d]++;
      if (nxt != m_st[d]) begin
        m_esc[d] = 0;
        m_rel[d] = 0;
      end
      m_st[d] = nxt;
    end
    x.st     = m_st[d];
    x.sevw   = (m_st[d] >= 2) ? 1 : 0;
    x.emgw   = (m_st[d] == 3) ? 1 : 0;
    x.sev_ev = m_sev_ev[d];
    x.emg_ev = m_emg_ev[d];
    if (d == 0) q_a.push_back(x);
    else        q_b.push_back(x);
  endtask

  task automatic drive(input bit r, input bit ts, input int w, input int v, input int t,
                       input bit ack);
    @(negedge CLK);
    RST          = r;
    thunderstorm = ts;
    wind         = 6'(w);
    visibility   = 2'(v);
    temperature  = 8'(t);
    alert_ack    = ack;
    model_step(0);
    model_step(1);
  endtask

  task automatic calm(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 5, 0, 20, 1'b0);
  endtask

  task automatic check_one(input int d);
    exp_t       x;
    logic [1:0] st;
    logic       sv, em;
    int         sev_ev, emg_ev;
    if (d == 0) begin
      if (q_a.size() == 0) return;
      x = q_a.pop_front(); st = st_a; sv = sev_a; em = emg_a;
    end else begin
      if (q_b.size() == 0) return;
      x = q_b.pop_front(); st = st_b; sv = sev_b; em = emg_b;
    end
    checks++;
    if (st !== 2'(x.st) || sv !== 1'(x.sevw) || em !== 1'(x.emgw)) begin
      errors++;
      $display("FAIL outputs dut%0d t=%0t: got state=%0d severe=%0b emerg=%0b required state=%0d severe=%0d emerg=%0d",
               d, $time, st, sv, em, x.st, x.sevw, x.emgw);
    end
`ifdef WSU_EVENT_LOG_EN
    sev_ev = (d == 0) ? int'(sev_ev_a) : int'(sev_ev_b);
    emg_ev = (d == 0) ? int'(emg_ev_a) : int'(emg_ev_b);
    checks++;
    if (sev_ev != x.sev_ev || emg_ev != x.emg_ev) begin
      errors++;
      $display("FAIL events dut%0d t=%0t: got severe_events=%0d emerg_events=%0d required %0d %0d",
               d, $time, sev_ev, emg_ev, x.sev_ev, x.emg_ev);
    end
`else
    sev_ev = 0;
    emg_ev = sev_ev;
`endif
  endtask

  // Monitor: compare one queued expectation per instance shortly after each rising edge
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      check_one(0);
      check_one(1);
    end
  end

  initial begin
    int cat, len, sub, w, v, t;
    bit ts, r, ack;
    RST = 1'b1; thunderstorm = 1'b0; wind = '0; visibility = '0; temperature = '0; alert_ack = 1'b0;

    drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 0, 0, 1'b0);
    // Single-cycle caution and return
    drive(1'b0, 1'b0, 12, 0, 20, 1'b0);
    calm(2);
    // Storm persistence: 2 cycles, then 3 cycles
    drive(1'b0, 1'b1, 5, 0, 20, 1'b0);
    drive(1'b0, 1'b1, 5, 0, 20, 1'b0);
    calm(4);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 5, 0, 20, 1'b0);
    // Emergency via cold, ignored ack, accepted ack
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 5, 0, -41, 1'b0);
    drive(1'b0, 1'b0, 5, 0, -41, 1'b1);
    drive(1'b0, 1'b0, 5, 0, -41, 1'b1);
    drive(1'b0, 1'b0, 5, 0, 0, 1'b1);
    // Hold-off interrupted by a storm blip
    calm(3);
    drive(1'b0, 1'b1, 5, 0, 20, 1'b0);
    calm(5);
    // Reset while severe wind arrives in CAUTION
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 12, 0, 20, 1'b0);
    drive(1'b1, 1'b0, 16, 0, 20, 1'b0);
    calm(2);
    // Boundary values
    drive(1'b0, 1'b0, 10, 0, 35, 1'b0);
    drive(1'b0, 1'b0, 15, 0, -35, 1'b0);
    drive(1'b0, 1'b0, 20, 0, 40, 1'b0);
    drive(1'b0, 1'b0, 20, 0, -40, 1'b0);
    drive(1'b0, 1'b0, 20, 0, -40, 1'b0);
    calm(6);

    // Randomized weather segments
    for (int s = 0; s < 700; s++) begin
      cat = int'($urandom_range(0, 9));
      len = int'($urandom_range(1, 6));
      r   = ($urandom_range(0, 49) == 0);
      for (int k = 0; k < len; k++) begin
        ts = 1'b0;
        w  = int'($urandom_range(0, 10));
        v  = 0;
        t  = int'($urandom_range(0, 70)) - 35;
        if (cat >= 4 && cat <= 5) begin
          if ($urandom_range(0, 1) == 0) w = int'($urandom_range(11, 15));
          else v = int'($urandom_range(1, 2));
        end else if (cat >= 6 && cat <= 7) begin
          sub = int'($urandom_range(0, 4));
          case (sub)
            0:       ts = 1'b1;
            1:       w = int'($urandom_range(16, 20));
            2:       v = 3;
            3:       t = int'($urandom_range(36, 40));
            default: t = -int'($urandom_range(36, 40));
          endcase
        end else if (cat >= 8) begin
          sub = int'($urandom_range(0, 2));
          if (sub == 0)      w = int'($urandom_range(21, 63));
          else if (sub == 1) t = int'($urandom_range(41, 127));
          else               t = -int'($urandom_range(41, 128));
        end
        ack = ($urandom_range(0, 3) == 0);
        drive(r && (k == 0), ts, w, v, t, ack);
      end
    end

    // Repeated CLEAR->SEVERE->CAUTION->CLEAR loops to saturate the severe entry count
    calm(8);
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 5, 0, 20, 1'b0);
      for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 12, 0, 20, 1'b0);
      calm(4);
    end
    drive(1'b1, 1'b0, 5, 0, 20, 1'b0);
    calm(2);

    @(posedge CLK);
    @(posedge CLK);
    #2;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expectations required 0/0", q_a.size(), q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
